booth_seq_divider: RTL
======================

// Module: booth_seq_divider
// PURPOSE
//  Sequential signed divider: the inverse of the 8x8 Booth multiplier. Takes a
//  2*W-bit two's-complement dividend (a multiplier product) and a W-bit signed
//  divisor; returns a W-bit quotient and a W-bit remainder.
//  Radix-2 restoring core on magnitudes, one quotient bit per clock.
//  Uses a start/busy/done handshake.
// PARAMETERS
//  W  8  divisor/quotient/remainder width; dividend is 2*W bits
// PORTS
//  clock      in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    request; sampled only while idle (busy=0)
//  dividend   in   2W   signed dividend, captured on accepted start
//  divisor    in   W    signed divisor, captured on accepted start
//  busy       out  1    high from the edge after accept until done
//  done       out  1    one-cycle pulse; results valid from this cycle on
//  quotient   out  W    signed quotient, truncated toward zero
//  remainder  out  W    signed remainder; takes the sign of the dividend
//  ovf        out  1    quotient outside [-2^(W-1), 2^(W-1)-1], or dbz
//  dbz        out  1    divisor was zero
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy, done, ovf, dbz = 0;
//   quotient and remainder = 0; all internal registers cleared.
//  FSM: IDLE -> ABS -> DIV -> FIX -> IDLE.
//  IDLE: start=1 at edge E0 latches the inputs; next state ABS; busy=1.
//  ABS (1 cycle): store |dividend| as 2W-bit unsigned (0x8000 = 32768 is legal)
//   and |divisor| as W-bit unsigned. Record sq = sign(dvd)^sign(dvs) and
//   sr = sign(dvd). Set dbz if divisor==0.
//  DIV (2W cycles): per cycle, shift {rem[W:0], mag} left by 1 and compute
//   trial = rem - |dvs| (W+1 bits). If trial >= 0: rem = trial, q bit = 1;
//   else q bit = 0. The full 2W-bit unsigned quotient is kept.
//  FIX (1 cycle): apply signs.
//   - Q = sq ? -q : q; R = sr ? -rem : rem.
//   - ovf when Q < -2^(W-1) or Q > 2^(W-1)-1. On overflow the quotient
//     saturates to 0x7F (positive) or 0x80 (negative); the remainder is the
//     true remainder.
//   - If dbz: quotient = 0, remainder = 0, ovf = 1, dbz = 1.
//   - Register the outputs; done=1 and busy=0 at this edge; go to IDLE.
//  Latency: done is high in the cycle after edge E0 + 2W+2, which is 18
//   clocks for W=8. Latency is fixed and also applies to dbz.
//  Outputs hold their values until the FIX edge of the next operation.
//   ovf and dbz are updated only at FIX.
//  start while busy: ignored, no queuing.
//  start in the done cycle: accepted, since the FSM is already back in IDLE.
//  Inputs need not be held after acceptance.
//  Reset mid-operation: immediate abort to the reset values; no done pulse.
// TESTING
//  1. 100/7 -> quotient=14, remainder=2, ovf=0; done exactly 18 clocks after
//     the start edge.
//  2. -100/7 -> q=0xF2 (-14), r=0xFE (-2); 100/-7 -> q=0xF2, r=2;
//     -100/-7 -> q=14, r=0xFE.
//  3. Multiplier inverse sweep: j=1..9, k=1..10 with dividend=j*k,
//     divisor=k -> q=j, r=0. Also dividend=j*k+1, divisor=k>1 -> q=j, r=1.
//  4. Overflow: 1000/3 -> ovf=1, q=0x7F, r=1. -16384/-128 -> ovf=1, q=0x7F.
//     -16384/128 is not representable as a divisor; use -16384/127 ->
//     ovf=1, q=0x80.
//  5. 1234/0 -> dbz=1, ovf=1, q=0, r=0, same 18-cycle latency.
//     -32768/-128 -> ovf=1, q=0x7F, r=0.
//  6. Start held high while busy -> exactly one done per accepted start.
//     rst_n pulse low at cycle 9 -> all outputs 0 immediately, no done;
//     the next start completes normally.

Source files
------------

// File: rtl/booth_seq_divider.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor, restoring radix-2
// on magnitudes, one quotient bit per clock, start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// ABS    | convert captured operands to magnitudes, record signs and dbz
// DIV    | 2W restoring steps, quotient bits shifted into mag_q
// FIX    | apply signs, saturate on overflow, register results, pulse done
module booth_seq_divider #(
  parameter int W = 8
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dbz
);

  localparam int CW = $clog2(2*W);
  localparam logic [2*W-1:0] QMAX   = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [W-1:0]   SAT_PS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   SAT_NG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ABS, S_DIV, S_FIX} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] mag_q, mag_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           sq_q, sq_d, sr_q, sr_d, zdiv_q, zdiv_d;
  logic           busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic [W-1:0]   quot_q, quot_d, remo_q, remo_d;

  logic [W:0]     rem_sh;
  logic           ge;
  logic [2*W-1:0] qlim;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    zdiv_d  = zdiv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    rem_sh  = {rem_q, mag_q[2*W-1]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    qlim    = sq_q ? (QMAX + {{(2*W-1){1'b0}}, 1'b1}) : QMAX;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_d   = dividend;
          dvs_d   = divisor;
          busy_d  = 1'b1;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        sr_d    = mag_q[2*W-1];
        sq_d    = mag_q[2*W-1] ^ dvs_q[W-1];
        mag_d   = mag_q[2*W-1] ? -mag_q : mag_q;
        dvs_d   = dvs_q[W-1] ? -dvs_q : dvs_q;
        zdiv_d  = (dvs_q == '0);
        rem_d   = '0;
        cnt_d   = CW'(2*W-1);
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = ge ? W'(rem_sh - {1'b0, dvs_q}) : rem_sh[W-1:0];
        mag_d = {mag_q[2*W-2:0], ge};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        if (zdiv_q) begin
          quot_d = '0;
          remo_d = '0;
          ovf_d  = 1'b1;
          dbz_d  = 1'b1;
        end else begin
          dbz_d  = 1'b0;
          remo_d = sr_q ? -rem_q : rem_q;
          // The magnitude bound is one larger for negative results (-2^(W-1)).
          if (mag_q > qlim) begin
            ovf_d  = 1'b1;
            quot_d = sq_q ? SAT_NG : SAT_PS;
          end else begin
            ovf_d  = 1'b0;
            quot_d = sq_q ? -mag_q[W-1:0] : mag_q[W-1:0];
          end
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      zdiv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      zdiv_q  <= zdiv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule
